// File: rtl/calc_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : calc_sequencer
//  Purpose  : Button debounce, operand latch and add/sub/shift-add-multiply
//             sequencing for the 7-bit calculator, with IR inactivity power-off.
//  Revision : 1.0  initial release
// ============================================================================
module calc_sequencer #(
    parameter int DEB_CYCLES   = 4,
    parameter int IDLE_TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  A,
    input  logic [6:0]  B,
    input  logic        b_lig,
    input  logic        b_soma,
    input  logic        b_sub,
    input  logic        b_multi,
    input  logic        sensorIR,
    output logic [13:0] Y,
    output logic        sinal,
    output logic        EN,
    output logic        busy,
    output logic        done
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [DW-1:0] C_DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] C_TIMEOUT  = TW'(IDLE_TIMEOUT);

    typedef enum logic [1:0] {
        S_OFF    = 2'd0,
        S_IDLE   = 2'd1,
        S_ADDSUB = 2'd2,
        S_MUL    = 2'd3
    } state_t;

    // Button order: [0] power, [1] add, [2] subtract, [3] multiply
    logic [3:0] w_raw;
    logic [3:0] w_press;
    assign w_raw = {b_multi, b_sub, b_soma, b_lig};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_deb
            logic          r_s1;
            logic          r_s2;
            logic          r_lvl;
            logic          r_pulse;
            logic [DW-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s1    <= 1'b0;
                    r_s2    <= 1'b0;
                    r_lvl   <= 1'b0;
                    r_pulse <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_s1    <= w_raw[gi];
                    r_s2    <= r_s1;
                    r_pulse <= 1'b0;
                    if (r_s2 == r_lvl) begin
                        r_cnt <= '0;
                    end else if (r_cnt == C_DEB_LAST) begin
                        // Level flips on the last of DEB_CYCLES differing samples
                        r_lvl   <= r_s2;
                        r_cnt   <= '0;
                        r_pulse <= r_s2;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_press[gi] = r_pulse;
        end
    endgenerate

    state_t          r_state;
    logic [6:0]      r_opa;
    logic [6:0]      r_opb;
    logic            r_is_sub;
    logic [13:0]     r_mcand;
    logic [6:0]      r_mplier;
    logic [13:0]     r_acc;
    logic [2:0]      r_step;
    logic [TW-1:0]   r_idle_cnt;

    logic            w_op_press;
    logic [7:0]      w_sum;
    logic [13:0]     w_mul_sum;

    assign w_op_press = w_press[1] | w_press[2] | w_press[3];
    assign w_sum      = {1'b0, r_opa} + {1'b0, r_opb};
    assign w_mul_sum  = r_acc + (r_mplier[0] ? r_mcand : 14'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_OFF;
            r_opa      <= '0;
            r_opb      <= '0;
            r_is_sub   <= 1'b0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
            r_step     <= '0;
            r_idle_cnt <= '0;
            Y          <= '0;
            sinal      <= 1'b0;
            EN         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (r_state == S_OFF) begin
                r_idle_cnt <= '0;
                if (w_press[0]) begin
                    r_state <= S_IDLE;
                    EN      <= 1'b1;
                end
            end else if (w_press[0]) begin
                // Power button wins over everything, aborting any operation
                r_state    <= S_OFF;
                r_idle_cnt <= '0;
                EN         <= 1'b0;
                busy       <= 1'b0;
                Y          <= '0;
                sinal      <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (w_op_press) begin
                            r_opa      <= A;
                            r_opb      <= B;
                            r_mcand    <= {7'd0, A};
                            r_mplier   <= B;
                            r_acc      <= '0;
                            r_step     <= '0;
                            r_is_sub   <= ~w_press[1] & w_press[2];
                            r_state    <= (w_press[1] | w_press[2]) ? S_ADDSUB : S_MUL;
                            busy       <= 1'b1;
                            r_idle_cnt <= '0;
                        end else if (sensorIR) begin
                            r_idle_cnt <= '0;
                        end else if (r_idle_cnt == C_TIMEOUT) begin
                            r_state    <= S_OFF;
                            r_idle_cnt <= '0;
                            EN         <= 1'b0;
                            Y          <= '0;
                            sinal      <= 1'b0;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + 1'b1;
                        end
                    end
                    S_ADDSUB: begin
                        if (!r_is_sub) begin
                            Y     <= {6'd0, w_sum};
                            sinal <= 1'b0;
                        end else if (r_opa < r_opb) begin
                            Y     <= {7'd0, r_opb - r_opa};
                            sinal <= 1'b1;
                        end else begin
                            Y     <= {7'd0, r_opa - r_opb};
                            sinal <= 1'b0;
                        end
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    S_MUL: begin
                        r_acc    <= w_mul_sum;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_step   <= r_step + 1'b1;
                        if (r_step == 3'd6) begin
                            Y       <= w_mul_sum;
                            sinal   <= 1'b0;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_OFF;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_calc_sequencer
//  Purpose  : Self-checking bench for calc_sequencer: vector table, corner
//             sequences and randomized operations against an arithmetic model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_calc_sequencer;

    localparam int DEB = 4;
    localparam int TO  = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  A;
    logic [6:0]  B;
    logic [3:0]  raw;
    logic        sensorIR;
    logic [13:0] Y;
    logic        sinal;
    logic        EN;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int last_y = 0;

    calc_sequencer #(
        .DEB_CYCLES   (DEB),
        .IDLE_TIMEOUT (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .b_lig    (raw[0]),
        .b_soma   (raw[1]),
        .b_sub    (raw[2]),
        .b_multi  (raw[3]),
        .sensorIR (sensorIR),
        .Y        (Y),
        .sinal    (sinal),
        .EN       (EN),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [3:0] mask;
        int         a;
        int         b;
        int         y;
        int         s;
    } vec_t;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Plain-arithmetic reference: add/sub/mul with soma > sub > multi priority
    function automatic void ref_calc(input logic [3:0] mask, input int a, input int b,
                                     output int y, output int s);
        if (mask[1]) begin
            y = a + b; s = 0;
        end else if (mask[2]) begin
            y = (a >= b) ? a - b : b - a;
            s = (a < b) ? 1 : 0;
        end else begin
            y = a * b; s = 0;
        end
    endfunction

    task automatic settle();
        repeat (DEB + 4) tick();
    endtask

    // Returns in the first cycle EN is expected high
    task automatic power_on(input string nm);
        raw[0] = 1'b1;
        repeat (2 + DEB) tick();
        check({nm, "_en_early"}, EN, 0);
        raw[0] = 1'b0;
        tick();
        check({nm, "_en"}, EN, 1);
        check({nm, "_y"}, Y, 0);
        check({nm, "_sinal"}, sinal, 0);
    endtask

    task automatic run_op(input string nm, input logic [3:0] mask, input int a, input int b,
                          input int ey, input int es);
        bit is_mul;
        bit bad;
        is_mul = !(mask[1] || mask[2]);
        bad = 0;
        A = a[6:0];
        B = b[6:0];
        raw = raw | mask;
        repeat (2 + DEB) tick();
        raw = raw & ~mask;
        check({nm, "_done_T"}, done, 0);
        tick();
        check({nm, "_busy_T1"}, busy, 1);
        A = 7'($urandom);
        B = 7'($urandom);
        if (is_mul) begin
            for (int i = 2; i <= 7; i++) begin
                tick();
                if (busy !== 1'b1 || done !== 1'b0) bad = 1;
            end
            check({nm, "_mul_busy_window"}, bad, 0);
        end
        tick();
        check({nm, "_done"}, done, 1);
        check({nm, "_busy_end"}, busy, 0);
        check({nm, "_y"}, Y, ey);
        check({nm, "_sinal"}, sinal, es);
        tick();
        check({nm, "_done_single"}, done, 0);
        last_y = ey;
        settle();
        check({nm, "_y_hold"}, Y, ey);
    endtask

    initial begin
        vec_t vecs[11];
        int   n;
        int   ey;
        int   es;
        bit   bad;
        logic [3:0] m;

        vecs[0]  = '{4'b0010, 100, 27, 127, 0};
        vecs[1]  = '{4'b0100, 5, 20, 15, 1};
        vecs[2]  = '{4'b0100, 9, 9, 0, 0};
        vecs[3]  = '{4'b1000, 127, 127, 16129, 0};
        vecs[4]  = '{4'b0010, 127, 127, 254, 0};
        vecs[5]  = '{4'b0100, 127, 0, 127, 0};
        vecs[6]  = '{4'b1000, 0, 99, 0, 0};
        vecs[7]  = '{4'b1000, 5, 7, 35, 0};
        vecs[8]  = '{4'b1010, 3, 4, 7, 0};
        vecs[9]  = '{4'b1100, 10, 3, 7, 0};
        vecs[10] = '{4'b1110, 1, 2, 3, 0};

        rst = 1'b1; raw = '0; sensorIR = 1'b1; A = '0; B = '0;
        repeat (3) tick();
        check("rst_y", Y, 0);
        check("rst_sinal", sinal, 0);
        check("rst_en", EN, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        tick();

        power_on("pwr1");
        settle();

        for (int i = 0; i < 11; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].mask, vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].s);
        end

        // Multiply with an add press landing in the middle of it
        A = 7'd127; B = 7'd127;
        raw[3] = 1'b1;
        repeat (2) tick();
        raw[1] = 1'b1;
        repeat (DEB) tick();
        raw[3] = 1'b0;
        tick(); tick();
        raw[1] = 1'b0;
        repeat (5) tick();
        check("busypress_busy_T7", busy, 1);
        tick();
        check("busypress_done", done, 1);
        check("busypress_y", Y, 16129);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) bad = 1;
        end
        check("busypress_no_extra", bad, 0);
        check("busypress_y_hold", Y, 16129);
        settle();

        // Glitch shorter than the debounce window
        raw[1] = 1'b1;
        repeat (DEB - 1) tick();
        raw[1] = 1'b0;
        bad = 0;
        for (int i = 0; i < DEB + 8; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) bad = 1;
        end
        check("glitch_no_op", bad, 0);
        check("glitch_y", Y, 16129);

        run_op("simul", 4'b1010, 3, 4, 7, 0);

        // Power-off press in the third multiply cycle
        A = 7'd127; B = 7'd127;
        raw[3] = 1'b1;
        repeat (3) tick();
        raw[0] = 1'b1;
        repeat (DEB - 1) tick();
        raw[3] = 1'b0;
        check("abort_busy_T", busy, 0);
        repeat (3) tick();
        check("abort_busy_T3", busy, 1);
        check("abort_en_T3", EN, 1);
        raw[0] = 1'b0;
        tick();
        check("abort_en", EN, 0);
        check("abort_y", Y, 0);
        check("abort_sinal", sinal, 0);
        check("abort_busy", busy, 0);
        bad = (done !== 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done !== 1'b0 || EN !== 1'b0) bad = 1;
        end
        check("abort_stays_off", bad, 0);

        // Plain inactivity timeout
        sensorIR = 1'b0;
        power_on("pwr2");
        n = -1;
        for (int i = 1; i <= 3 * TO; i++) begin
            tick();
            if (EN !== 1'b1) begin n = i; break; end
        end
        check("timeout_cycles", n, TO + 1);

        // Sensor pulse just before expiry restarts the count
        power_on("pwr3");
        repeat (TO - 1) tick();
        sensorIR = 1'b1;
        tick();
        sensorIR = 1'b0;
        n = -1;
        for (int i = 1; i <= 3 * TO; i++) begin
            tick();
            if (EN !== 1'b1) begin n = i; break; end
        end
        check("timeout_restart_cycles", n, TO + 1);
        check("timeout_y", Y, 0);

        // Randomized operations against the reference model
        sensorIR = 1'b1;
        power_on("pwr4");
        settle();
        for (int i = 0; i < 16; i++) begin
            m = {3'($urandom_range(1, 7)), 1'b0};
            n = int'($urandom_range(0, 127));
            ref_calc(m, n, int'($urandom_range(0, 127)), ey, es);
            // Recover b from the model inputs by recomputing with a fresh draw
            begin
                int bb;
                bb = int'($urandom_range(0, 127));
                ref_calc(m, n, bb, ey, es);
                run_op($sformatf("rnd%0d", i), m, n, bb, ey, es);
            end
        end

        // Reset in the middle of a multiply
        A = 7'd99; B = 7'd77;
        raw[3] = 1'b1;
        repeat (2 + DEB) tick();
        raw[3] = 1'b0;
        repeat (3) tick();
        check("rstmid_busy", busy, 1);
        rst = 1'b1;
        tick();
        check("rstmid_y", Y, 0);
        check("rstmid_sinal", sinal, 0);
        check("rstmid_en", EN, 0);
        check("rstmid_busy0", busy, 0);
        check("rstmid_done", done, 0);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done !== 1'b0 || EN !== 1'b0) bad = 1;
        end
        check("rstmid_quiet", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/calc_sequencer.md
# calc_sequencer

Control and sequencing block for the 7-bit calculator datapath. It debounces the four front-panel buttons (power, add, subtract, multiply) and latches operands A and B on an operation request. It runs the selected operation, using a multi-cycle shift-add for multiply, and presents a registered 14-bit magnitude result with a sign flag. It also drives the display enable and powers the unit off after a period with no presence on the IR sensor.

## Interface
Parameters:
- DEB_CYCLES, 4: number of consecutive stable synchronized samples required before a button level change is accepted.
- IDLE_TIMEOUT, 1000: consecutive IDLE cycles with sensorIR=0 after which the unit powers off.

Ports:
- clk  input  1  system clock. One clock domain for the whole block.
- rst  input  1  reset. Synchronous and active-high.
- A  input  7  operand A, unsigned.
- B  input  7  operand B, unsigned.
- b_lig  input  1  power toggle button, raw, active-high.
- b_soma  input  1  add button, raw, active-high.
- b_sub  input  1  subtract button, raw, active-high.
- b_multi  input  1  multiply button, raw, active-high.
- sensorIR  input  1  presence sensor, active-high.
- Y  output  14  result magnitude, registered.
- sinal  output  1  result sign. 1 means negative.
- EN  output  1  display enable. 1 in every state except OFF.
- busy  output  1  high while an operation executes.
- done  output  1  one-cycle pulse when a new result lands in Y.

## Operation
- Each button passes through a 2-FF synchronizer, then a debounce counter. The debounced level changes only after DEB_CYCLES equal samples. A press is a one-cycle pulse on the debounced rising edge. Releases generate nothing.
- FSM states are OFF, IDLE, ADDSUB and MUL. All outputs are reset values in OFF.
- OFF: a b_lig press moves the FSM to IDLE. Operation presses are ignored.
- IDLE: the first operation press latches A and B into internal registers.
  - Add or subtract goes to ADDSUB. Multiply goes to MUL.
  - Priority for simultaneous presses is soma > sub > multi. Only one operation starts.
- ADDSUB lasts 1 cycle.
  - Add: Y = A+B, with a maximum of 254. sinal=0.
  - Subtract: Y = |A-B|. sinal=1 exactly when A<B. A=B gives Y=0 and sinal=0.
  - The FSM then returns to IDLE.
- MUL lasts 7 cycles of shift-add over the 7 multiplier bits into an internal 14-bit accumulator. At the end, Y = A*B (maximum 16129) and sinal=0. The FSM returns to IDLE.
- Operation presses during ADDSUB or MUL are dropped, not queued.
- Y and sinal hold the last result until the next operation completes. A and B may change freely after the latch.
- A b_lig press in any ON state (IDLE, ADDSUB or MUL) goes to OFF on the next cycle.
  - An in-flight operation is aborted with no done pulse.
  - Y and sinal are cleared to 0.
- Inactivity timer:
  - Counts only in IDLE while sensorIR=0.
  - Clears on sensorIR=1, on any press, and on leaving IDLE.
  - Reaching IDLE_TIMEOUT forces OFF and clears Y and sinal.
- busy = (state==ADDSUB) or (state==MUL). EN = (state!=OFF).

## Timing
- Reset values:
  - State: OFF.
  - Outputs: Y=0, sinal=0, EN=0, busy=0, done=0.
  - Internal: synchronizers, debounce levels, counters and operand registers all cleared.
- Press latency: the press pulse arrives 2+DEB_CYCLES cycles after the raw input goes stable high.
- Timing reference: press pulse in IDLE at cycle T.
  - Add or subtract: busy=1 at T+1. Y, sinal and done=1 at T+2. busy=0 at T+2.
  - Multiply: busy=1 for T+1..T+7. Y and done=1 at T+8.
- Power-on press at cycle T: EN=1 at T+1. Power-off press at cycle T: EN=0, Y=0 and sinal=0 at T+1.
- Timeout: with sensorIR=0 throughout IDLE, EN falls IDLE_TIMEOUT+1 cycles after entering IDLE.
- Reset asserted mid-operation: the next cycle shows all reset values and done does not pulse.
- done never asserts for two consecutive cycles. Back-to-back operations need a new debounced press.

## Test plan
- Reset, then b_lig held stable: EN=1 exactly 3+DEB_CYCLES cycles after the raw edge. Y=0 and sinal=0.
- A=100, B=27, add press: Y=127, sinal=0 and done pulse 2 cycles after the press pulse. A=5, B=20, subtract: Y=15, sinal=1. A=B=9, subtract: Y=0, sinal=0.
- A=B=127, multiply: busy high for 7 cycles, then Y=16129 and done. A b_soma press during busy leaves Y=16129 with no extra done.
- Raw b_soma glitch of DEB_CYCLES-1 cycles produces no press and Y is unchanged. b_soma and b_multi debounced in the same cycle with A=3, B=4 give Y=7.
- b_lig press at the 3rd MUL cycle: no done, EN=0, Y=0 and sinal=0 next cycle.
- IDLE with sensorIR=0 for IDLE_TIMEOUT-1 cycles, one sensorIR=1 pulse, then sensorIR=0: the unit stays on until a full IDLE_TIMEOUT elapses, then EN=0.
